axis_data_fifo_sync: RTL and testbench
======================================

// Module: axis_data_fifo_sync
// PURPOSE
//  Single-clock AXI4-Stream FIFO for the same datapath as the dual-clock stream FIFO.
//  - Parametrised width/depth; carries tlast.
//  - Adds programmable almost-full/almost-empty flags, write- and read-side occupancy counts.
//  - Optional packet (store-and-forward) mode.
//  - Sits between stream producers/consumers that share one clock, e.g. pixel pipeline stage decoupling.
// PARAMETERS
//  DEPTH             1024        entries in RAM; power of two, >= 4; AW = $clog2(DEPTH)
//  DW                32          tdata width, >= 1
//  PROG_FULL_THRESH  DEPTH-16    prog_full asserts when ram_count >= this; range 1..DEPTH
//  PROG_EMPTY_THRESH 16          prog_empty asserts when ram_count <= this; range 0..DEPTH-1
// PORTS
//  axis_aclk           in   1       single clock, all logic on rising edge
//  axis_areset         in   1       synchronous, active-high reset
//  s_axis_tvalid       in   1       write-side valid
//  s_axis_tready       out  1       write-side ready (= not full)
//  s_axis_tdata        in   DW      write data
//  s_axis_tlast        in   1       end-of-packet marker
//  m_axis_tvalid       out  1       read-side valid (registered)
//  m_axis_tready       in   1       read-side ready
//  m_axis_tdata        out  DW      read data (registered RAM output)
//  m_axis_tlast        out  1       end-of-packet marker, aligned with m_axis_tdata
//  axis_wr_data_count  out  32      ram_count, zero-extended
//  axis_rd_data_count  out  32      ram_count + m_axis_tvalid (0..DEPTH+1), zero-extended
//  prog_full           out  1       ram_count >= PROG_FULL_THRESH
//  prog_empty          out  1       ram_count <= PROG_EMPTY_THRESH
// BEHAVIOUR
//  - Storage: DEPTH x (DW+1) inferable RAM {tlast,tdata}.
//    wptr/rptr are AW+1 bits, wrap naturally mod 2*DEPTH; ram_count = wptr - rptr (AW+1 bits).
//  - full = (ram_count == DEPTH); empty = (ram_count == 0).
//    s_axis_tready = ~full & ~axis_areset.
//  - wr = s_axis_tvalid & s_axis_tready: write RAM[wptr], wptr++.
//  - rd_ext = ~m_axis_tvalid | m_axis_tready; rd = ~empty & rd_ext & pkt_ok.
//    On rd: output reg <= RAM[rptr], rptr++.
//  - On rd_ext: m_axis_tvalid <= rd. Otherwise tvalid/tdata/tlast hold; they are stable while stalled.
//  - Latency: word accepted at edge k into an empty FIFO (output reg empty) gives m_axis_tvalid=1 after edge k+1.
//    No combinational bypass.
//  - Full + simultaneous read: the write is refused that cycle (tready=0); space is visible the next cycle.
//  - Empty + simultaneous write: the read does not occur that cycle.
//  - Full throughput: 1 word/clock sustained in steady state.
//  - Reset (axis_areset=1 at an edge): wptr, rptr, pkt_count, m_axis_tvalid cleared.
//    All counts read 0; prog_empty=1, prog_full=0; RAM contents are discarded, not cleared.
//    Applies mid-packet or mid-burst with no partial output. s_axis_tready=1 from the first cycle after reset drops.
//  - Outputs m_axis_tdata/m_axis_tlast are don't-care while m_axis_tvalid=0.
// CONFIGURATION
//  AXIS_FIFO_PACKET_MODE_EN
//  - Defined:
//    - Keeps pkt_count (AW+1 bits) = number of tlast words in RAM.
//      +1 on wr with s_axis_tlast; -1 on rd of a word with tlast; both in one cycle leaves it unchanged.
//    - pkt_ok = (pkt_count != 0) | full. Full releases a packet longer than DEPTH to avoid deadlock.
//  - Undefined: pkt_ok = 1 (cut-through); no pkt_count register.
// TESTING
//  1. Reset, write 0x00..0x09 (tlast on 0x09), m_axis_tready=1
//     -> same order out; tlast only on 0x09; tvalid one edge after first accept.
//  2. m_axis_tready=0, write until stall
//     -> s_axis_tready=0 at ram_count=DEPTH; axis_rd_data_count=DEPTH+1; prog_full=1.
//     Then one read -> tready=1 next cycle; no word lost or duplicated.
//  3. Both sides valid/ready every cycle for 4*DEPTH words (pointer wrap)
//     -> 1 word/clk after fill; ram_count constant; data in order.
//  4. Random tvalid/tready (50%) over 10k words
//     -> scoreboard match; tdata stable whenever tvalid & ~tready.
//  5. Assert axis_areset mid-burst with ram_count=37
//     -> next cycle counts=0, m_axis_tvalid=0, prog_empty=1; post-reset stream is clean.
//  6. AXIS_FIFO_PACKET_MODE_EN: write a 5-word packet, tlast held off for 3 idle cycles
//     -> m_axis_tvalid stays 0 until tlast accepted.
//     Packet of DEPTH+3 words -> forwarded once full (no deadlock).

Source files
------------

// File: rtl/axis_data_fifo_sync.sv
// axis_data_fifo_sync: single-clock AXI4-Stream FIFO carrying tlast, with programmable flags and occupancy counts.
// Optional store-and-forward packet mode is enabled by defining AXIS_FIFO_PACKET_MODE_EN.
`timescale 1ns/1ps
module axis_data_fifo_sync #(
    parameter int DEPTH             = 1024,
    parameter int DW                = 32,
    parameter int PROG_FULL_THRESH  = DEPTH - 16,
    parameter int PROG_EMPTY_THRESH = 16
) (
    input  logic          axis_aclk,
    input  logic          axis_areset,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tlast,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tlast,
    output logic [31:0]   axis_wr_data_count,
    output logic [31:0]   axis_rd_data_count,
    output logic          prog_full,
    output logic          prog_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] PF_W    = (AW+1)'(PROG_FULL_THRESH);
    localparam logic [AW:0] PE_W    = (AW+1)'(PROG_EMPTY_THRESH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("axis_data_fifo_sync: DEPTH must be a power of two >= 4");
    end
    if (PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > DEPTH) begin : g_pf_chk
        $error("axis_data_fifo_sync: PROG_FULL_THRESH out of range 1..DEPTH");
    end
    if (PROG_EMPTY_THRESH < 0 || PROG_EMPTY_THRESH > DEPTH - 1) begin : g_pe_chk
        $error("axis_data_fifo_sync: PROG_EMPTY_THRESH out of range 0..DEPTH-1");
    end

    logic [DW:0] mem [DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, ram_count;
    logic        full, empty, wr, rd, rd_ext, pkt_ok;
    logic        tvalid_q, tvalid_d;
    logic [DW:0] out_q, rd_word;

    // Core flow control: occupancy, handshakes and pointer/valid next state.
    always_comb begin
        ram_count     = wptr_q - rptr_q;
        full          = ram_count == DEPTH_W;
        empty         = ram_count == '0;
        rd_word       = mem[rptr_q[AW-1:0]];
        s_axis_tready = ~full & ~axis_areset;
        wr            = s_axis_tvalid & s_axis_tready;
        rd_ext        = ~tvalid_q | m_axis_tready;
        rd            = ~empty & rd_ext & pkt_ok;
        wptr_d        = wptr_q + (AW+1)'(wr);
        rptr_d        = rptr_q + (AW+1)'(rd);
        tvalid_d      = rd_ext ? rd : tvalid_q;
    end

`ifdef AXIS_FIFO_PACKET_MODE_EN
    logic [AW:0] pkt_count_q, pkt_count_d;

    // Count complete packets in RAM; a full RAM also releases data so oversized packets cannot deadlock.
    always_comb begin
        pkt_ok      = (pkt_count_q != '0) | full;
        pkt_count_d = pkt_count_q + (AW+1)'(wr & s_axis_tlast) - (AW+1)'(rd & rd_word[DW]);
    end

    // Packet counter register.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) pkt_count_q <= '0;
        else             pkt_count_q <= pkt_count_d;
    end
`else
    // Cut-through: any stored word may be forwarded.
    always_comb pkt_ok = 1'b1;
`endif

    // Pointer and output-valid state; reset drops any partially delivered burst.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            tvalid_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            tvalid_q <= tvalid_d;
        end
    end

    // Storage array {tlast, tdata}; contents are never cleared.
    always_ff @(posedge axis_aclk) begin
        if (wr) mem[wptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end

    // Registered read port; holds while the consumer stalls.
    always_ff @(posedge axis_aclk) begin
        if (rd) out_q <= rd_word;
    end

    // Output mapping and status.
    always_comb begin
        m_axis_tvalid      = tvalid_q;
        m_axis_tdata       = out_q[DW-1:0];
        m_axis_tlast       = out_q[DW];
        axis_wr_data_count = 32'(ram_count);
        axis_rd_data_count = 32'(ram_count) + 32'(tvalid_q);
        prog_full          = ram_count >= PF_W;
        prog_empty         = ram_count <= PE_W;
    end
endmodule

// File: tb/tb_axis_data_fifo_sync.sv
// tb_axis_data_fifo_sync: directed and random stream tests for axis_data_fifo_sync with a scoreboard.
`timescale 1ns/1ps
module tb_axis_data_fifo_sync;
    localparam int DEPTH = 64;
    localparam int DW    = 32;
    localparam int PF_T  = 48;
    localparam int PE_T  = 16;
`ifdef AXIS_FIFO_PACKET_MODE_EN
    localparam bit PKT = 1'b1;
`else
    localparam bit PKT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_axis_tready, m_axis_tvalid, m_axis_tlast, prog_full, prog_empty;
    logic [DW-1:0] m_axis_tdata;
    logic [31:0]   wr_count, rd_count;

    int          checks = 0, errors = 0, nxt = 0;
    bit          hashed = 1'b0, s_hs, m_hs, prev_stall, rst_at_edge;
    logic [DW:0] sb [$];
    logic [DW:0] prev_word, exp_word;

    axis_data_fifo_sync #(.DEPTH(DEPTH), .DW(DW), .PROG_FULL_THRESH(PF_T), .PROG_EMPTY_THRESH(PE_T)) dut (
        .axis_aclk(clk), .axis_areset(rst),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_data), .s_axis_tlast(s_last),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_ready), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .axis_wr_data_count(wr_count), .axis_rd_data_count(rd_count),
        .prog_full(prog_full), .prog_empty(prog_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] dat(input int n);
        return hashed ? DW'(n) * 32'h9E37_79B1 : DW'(n);
    endfunction

    always @(posedge clk) rst_at_edge <= rst;

    // Mid-cycle monitor: scoreboard push/pop and stall-stability check.
    always @(negedge clk) begin
        if (rst_at_edge) begin
            sb.delete();
            prev_stall = 1'b0;
        end
        s_hs = s_valid & s_axis_tready;
        m_hs = m_axis_tvalid & m_ready;
        if (prev_stall) begin
            chk("stall_valid", m_axis_tvalid, 1);
            chk("stall_word", {m_axis_tlast, m_axis_tdata}, prev_word);
        end
        if (m_hs) begin
            chk("sb_pending", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp_word = sb.pop_front();
                chk("sb_word", {m_axis_tlast, m_axis_tdata}, exp_word);
            end
        end
        if (s_hs) sb.push_back({s_last, s_data});
        prev_stall = m_axis_tvalid & ~m_ready;
        prev_word  = {m_axis_tlast, m_axis_tdata};
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (s_hs) begin
            nxt++;
            s_data = dat(nxt);
        end
    endtask

    task automatic stream(input int n, input int pv, input int pr, input int lp);
        int sent = 0;
        int cyc = 0;
        s_data = dat(nxt);
        s_last = (n == 1);
        while (sent < n && cyc < 40 * n + 4 * DEPTH) begin
            if (!s_valid) s_valid = ($urandom_range(99) < pv);
            m_ready = ($urandom_range(99) < pr);
            tick();
            cyc++;
            if (s_hs) begin
                sent++;
                s_valid = 1'b0;
                s_last = (sent == n - 1) || ($urandom_range(99) < lp);
            end
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        chk("stream_sent", sent, n);
    endtask

    task automatic drain();
        int cyc = 0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        while ((sb.size() != 0 || m_axis_tvalid) && cyc < 4 * DEPTH + 50) begin
            tick();
            cyc++;
        end
        #2;
        chk("drain_sb_empty", sb.size(), 0);
        chk("drain_rd_count", rd_count, 0);
    endtask

    initial begin
        #3ms;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int ram;
        repeat (2) tick();
        #2;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_rd_count", rd_count, 0);
        chk("rst_prog_empty", prog_empty, 1);
        chk("rst_prog_full", prog_full, 0);
        chk("rst_tready", s_axis_tready, 0);
        tick();
        rst = 1'b0;
        // Test 1: ordered packet 0x00..0x09, tlast on 0x09, with first-word latency.
        s_valid = 1'b1; s_data = dat(0); s_last = 1'b0; m_ready = 1'b1;
        #2;
        chk("t1_tready_after_rst", s_axis_tready, 1);
        tick();
        #2;
        chk("t1_tvalid_edge_k", m_axis_tvalid, 0);
        tick();
        #2;
        chk("t1_tvalid_edge_k1", m_axis_tvalid, PKT ? 0 : 1);
        stream(8, 100, 100, 0);
        drain();
        // Test 2: fill to full with the consumer stalled, boundary flags every cycle.
        hashed = 1'b1;
        s_data = dat(nxt); s_last = PKT; s_valid = 1'b1; m_ready = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            tick();
            #2;
            ram = i - (i >= 2 ? 1 : 0);
            chk("t2_wr_count", wr_count, ram);
            chk("t2_rd_count", rd_count, ram + (i >= 2 ? 1 : 0));
            chk("t2_prog_full", prog_full, ram >= PF_T);
            chk("t2_prog_empty", prog_empty, ram <= PE_T);
            chk("t2_tready", s_axis_tready, ram != DEPTH);
        end
        chk("t2_full_rd_count", rd_count, DEPTH + 1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        #2;
        chk("t2_space_tready", s_axis_tready, 1);
        chk("t2_space_wr_count", wr_count, DEPTH - 1);
        tick();
        s_valid = 1'b0;
        #2;
        chk("t2_refull_tready", s_axis_tready, 0);
        drain();
        // Test 3: sustained one word per clock across pointer wrap.
        s_valid = 1'b1; s_last = PKT; m_ready = 1'b0;
        repeat (32) tick();
        #2;
        chk("t3_fill_rd_count", rd_count, 32);
        chk("t3_fill_wr_count", wr_count, 31);
        m_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            tick();
            #2;
            chk("t3_rd_count", rd_count, 32);
            chk("t3_both_hs", s_valid & s_axis_tready & m_axis_tvalid & m_ready, 1);
        end
        s_valid = 1'b0;
        drain();
        // Test 4: random valid/ready over 10k words.
        stream(10000, 50, 50, 15);
        drain();
        // Test 5: reset mid-burst with 37 words in RAM.
        s_valid = 1'b1; s_last = PKT; m_ready = 1'b0;
        repeat (38) tick();
        #2;
        chk("t5_wr_count", wr_count, 37);
        chk("t5_rd_count", rd_count, 38);
        chk("t5_prog_empty", prog_empty, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s_valid = 1'b0;
        #2;
        chk("t5_wr_count_rst", wr_count, 0);
        chk("t5_rd_count_rst", rd_count, 0);
        chk("t5_tvalid_rst", m_axis_tvalid, 0);
        chk("t5_prog_empty_rst", prog_empty, 1);
        chk("t5_prog_full_rst", prog_full, 0);
        chk("t5_tready_rst", s_axis_tready, 1);
        stream(20, 100, 100, 0);
        drain();
`ifdef AXIS_FIFO_PACKET_MODE_EN
        // Test 6: packet held back until tlast, then an oversized packet.
        s_valid = 1'b1; s_last = 1'b0; m_ready = 1'b1;
        repeat (4) begin
            tick();
            #2;
            chk("t6_hold_write", m_axis_tvalid, 0);
        end
        s_valid = 1'b0;
        repeat (3) begin
            tick();
            #2;
            chk("t6_hold_idle", m_axis_tvalid, 0);
        end
        s_valid = 1'b1; s_last = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        #2;
        chk("t6_tlast_edge_k", m_axis_tvalid, 0);
        tick();
        #2;
        chk("t6_tlast_edge_k1", m_axis_tvalid, 1);
        drain();
        stream(DEPTH + 3, 100, 100, 0);
        drain();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
